hamming_dec_sched: RTL and testbench
====================================

HAMMING_DEC_SCHED -- requirements
Module: hamming_dec_sched

Interface
REQ-001 SHALL have parameter CNT_W, default 8, giving the width of the error counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester N offers a codeword.
REQ-005 SHALL have ports req0_data / req1_data  input  7  requester N's 7-bit Hamming codeword; bit i is codeword position i+1, with parity bits at bits 0, 1 and 3.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  requester N's codeword is accepted this cycle.
REQ-007 SHALL have port mode  input  1  1 = even parity, 0 = odd parity; sampled at accept.
REQ-008 SHALL have port out_valid  output  1  corrected result is available.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 SHALL have port out_data  output  7  corrected codeword.
REQ-011 SHALL have port out_nibble  output  4  decoded data bits, ordered {c6,c5,c4,c2}.
REQ-012 SHALL have port out_syndrome  output  3  {s4,s2,s1}.
REQ-013 SHALL have port out_err  output  1  syndrome is non-zero.
REQ-014 SHALL have port out_id  output  1  index of the requester that supplied the codeword.
REQ-015 SHALL have port err_cnt  output  CNT_W  saturating count of corrected codewords.
REQ-016 SHALL have port clr_cnt  input  1  synchronous clear of err_cnt.
REQ-017 SHALL have port busy  output  1  high in every state other than IDLE.

Function
REQ-018 SHALL implement the states IDLE, CHK1, CHK2, CHK4, FIX and OUT.
REQ-019 In IDLE, if any reqN_valid is high, SHALL combinationally assert the winner's reqN_ready, latch its codeword, latch mode and latch the winner's index, then move to CHK1.
REQ-020 Arbitration SHALL be round-robin: a lone valid requester wins; when both are valid, the requester not granted last wins; last_grant SHALL reset to 1, so req0 wins the first tie.
REQ-021 reqN_ready SHALL be low in every state except IDLE, and SHALL never be asserted to both requesters in the same cycle.
REQ-022 CHK1, CHK2 and CHK4 SHALL each take one cycle and register, in that order:
  - s1 = c0^c2^c4^c6
  - s2 = c1^c2^c5^c6
  - s4 = c3^c4^c5^c6
  - in odd mode, each syndrome bit SHALL be inverted.
REQ-023 In FIX, a non-zero syndrome S SHALL invert codeword bit S-1, and a zero syndrome SHALL leave the codeword unchanged; the state then moves to OUT.
REQ-024 In FIX, a non-zero syndrome SHALL increment err_cnt, which holds at all-ones rather than wrapping.
REQ-025 clr_cnt SHALL zero err_cnt in any state, and SHALL take priority over a simultaneous increment.
REQ-026 In OUT, out_valid SHALL be high and all out_* outputs SHALL be stable; when out_ready is high, the state SHALL move to IDLE.
REQ-027 out_valid SHALL be high only in OUT.
REQ-028 Latency from the accept cycle T SHALL be: out_valid high at T+5; the earliest next accept is the cycle after the out_ready handshake (peak throughput 1 codeword / 6 cycles).
REQ-029 Changes on mode or reqN_data after accept SHALL NOT affect the codeword in flight.
REQ-030 A requester held off by backpressure SHALL keep its valid asserted and SHALL be granted on the next IDLE according to round-robin.

Reset
REQ-031 On rst_n low, at any time including mid-operation, the block SHALL asynchronously:
  - go to IDLE and discard any in-flight codeword
  - drive out_valid, busy, req0_ready and req1_ready low
  - drive out_data, out_nibble, out_syndrome, out_err, out_id and err_cnt to 0
  - set last_grant to 1
REQ-032 After rst_n is released, the first accept SHALL be possible on the first rising clock edge.

Verification
REQ-033 Even mode, req0_data=7'h66, out_ready=1 -> out_valid at T+5 with out_data=7'h66, out_nibble=4'hD, out_syndrome=0, out_err=0, err_cnt unchanged.
REQ-034 Even mode, req1_data=7'h76 -> out_syndrome=3'b101, out_data=7'h66, out_err=1, out_id=1, err_cnt increments by 1.
REQ-035 Odd mode, 7'h6D -> out_syndrome=0, out_data=7'h6D; then 7'h6C (bit 0 flipped) -> out_syndrome=3'b001, out_data=7'h6D.
REQ-036 Both requesters valid continuously after reset -> grant order 0,1,0,1; out_id alternates; no double ready.
REQ-037 out_ready low for 10 cycles in OUT -> outputs held, no new accept; then rst_n pulsed mid-CHK2 -> out_valid=0, state IDLE, err_cnt=0.
REQ-038 CNT_W=2, five erroneous codewords -> err_cnt saturates at 3; clr_cnt coincident with a FIX error -> err_cnt=0.

Source files
------------

// File: rtl/hamming_dec_sched_if.sv
// Handshake bundle for the Hamming decode scheduler:
// two codeword requesters and one result consumer.
interface hamming_dec_sched_if;
  logic       req0_valid;
  logic       req1_valid;
  logic [6:0] req0_data;
  logic [6:0] req1_data;
  logic       req0_ready;
  logic       req1_ready;
  logic       mode;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_data;
  logic [3:0] out_nibble;
  logic [2:0] out_syndrome;
  logic       out_err;
  logic       out_id;

  modport master (
    output req0_valid,
    output req1_valid,
    output req0_data,
    output req1_data,
    output mode,
    output out_ready,
    input  req0_ready,
    input  req1_ready,
    input  out_valid,
    input  out_data,
    input  out_nibble,
    input  out_syndrome,
    input  out_err,
    input  out_id
  );

  modport slave (
    input  req0_valid,
    input  req1_valid,
    input  req0_data,
    input  req1_data,
    input  mode,
    input  out_ready,
    output req0_ready,
    output req1_ready,
    output out_valid,
    output out_data,
    output out_nibble,
    output out_syndrome,
    output out_err,
    output out_id
  );
endinterface

// File: rtl/hamming_dec_sched.sv
// Two-requester Hamming(7,4) decoder: round-robin accept,
// one syndrome bit per cycle, single-bit fix, saturating error count.
module hamming_dec_sched #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy,
  hamming_dec_sched_if.slave bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CHK1 = 3'd1;
  localparam logic [2:0] CHK2 = 3'd2;
  localparam logic [2:0] CHK4 = 3'd3;
  localparam logic [2:0] FIX  = 3'd4;
  localparam logic [2:0] OUT  = 3'd5;

  logic [2:0] state;
  logic [2:0] state_n;
  logic [6:0] cw;
  logic       even;
  logic [2:0] syn;
  logic       id;
  logic       last_grant;
  logic       idle;
  logic       gnt0;
  logic       gnt1;
  logic       acc;
  logic       p1;
  logic       p2;
  logic       p4;
  logic [6:0] flip;
  logic       inc;

  // Ready is gated by rst_n so nothing is granted while reset is held.
  always_comb begin
    idle = (state == IDLE);
    gnt0 = idle & rst_n & bus.req0_valid
         & (~bus.req1_valid | last_grant);
    gnt1 = idle & rst_n & bus.req1_valid & ~gnt0;
    acc  = gnt0 | gnt1;
  end

  // Odd mode inverts every check bit.
  always_comb begin
    p1 = cw[0] ^ cw[2] ^ cw[4] ^ cw[6] ^ ~even;
    p2 = cw[1] ^ cw[2] ^ cw[5] ^ cw[6] ^ ~even;
    p4 = cw[3] ^ cw[4] ^ cw[5] ^ cw[6] ^ ~even;
  end

  always_comb begin
    flip = '0;
    if (syn != 3'd0)
      flip = 7'(1) << (syn - 3'd1);
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (acc) state_n = CHK1;
      CHK1:    state_n = CHK2;
      CHK2:    state_n = CHK4;
      CHK4:    state_n = FIX;
      FIX:     state_n = OUT;
      OUT:     if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cw         <= '0;
      even       <= 1'b0;
      syn        <= '0;
      id         <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (acc) begin
            cw         <= gnt0 ? bus.req0_data
                               : bus.req1_data;
            even       <= bus.mode;
            id         <= gnt1;
            last_grant <= gnt1;
            syn        <= '0;
          end
        end
        CHK1:    syn[0] <= p1;
        CHK2:    syn[1] <= p2;
        CHK4:    syn[2] <= p4;
        FIX:     cw     <= cw ^ flip;
        default: ;
      endcase
    end
  end

  assign inc = (state == FIX) & (syn != 3'd0);

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (clr_cnt)
      err_cnt <= '0;
    else if (inc && !(&err_cnt))
      err_cnt <= err_cnt + 1'b1;
  end

  assign busy             = ~idle;
  assign bus.req0_ready   = gnt0;
  assign bus.req1_ready   = gnt1;
  assign bus.out_valid    = (state == OUT);
  assign bus.out_data     = cw;
  assign bus.out_nibble   = {cw[6], cw[5], cw[4], cw[2]};
  assign bus.out_syndrome = syn;
  assign bus.out_err      = |syn;
  assign bus.out_id       = id;

endmodule

// File: tb/tb_hamming_dec_sched.sv
// Directed bench for hamming_dec_sched: vector table plus
// arbitration, backpressure, reset and saturation sequences.
module tb_hamming_dec_sched;

  typedef struct {
    logic       id;
    logic       mode;
    logic [6:0] din;
    logic [6:0] dout;
    logic [3:0] nib;
    logic [2:0] syn;
    logic       err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_cnt = 1'b0;
  logic       clr2 = 1'b0;
  logic [7:0] err_cnt;
  logic [1:0] cnt2;
  logic       busy;
  logic       busy2;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  vec_t vt[10];

  hamming_dec_sched_if bus ();
  hamming_dec_sched_if bus2 ();

  hamming_dec_sched u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_cnt (clr_cnt),
    .err_cnt (err_cnt),
    .busy    (busy),
    .bus     (bus)
  );

  hamming_dec_sched #(.CNT_W(2)) u_sat (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_cnt (clr2),
    .err_cnt (cnt2),
    .busy    (busy2),
    .bus     (bus2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic drive(input logic id, input logic v,
                       input logic [6:0] d,
                       input logic m);
    bus.mode = m;
    if (id) begin
      bus.req1_valid = v;
      bus.req1_data  = d;
    end else begin
      bus.req0_valid = v;
      bus.req0_data  = d;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    @(negedge clk);
    drive(v.id, 1'b1, v.din, v.mode);
    #1;
    chk("vec_ready",
        {30'd0, bus.req1_ready, bus.req0_ready},
        v.id ? 32'd2 : 32'd1);
    @(posedge clk);
    #1;
    drive(v.id, 1'b0, ~v.din, ~v.mode);
    if (v.err) exp_cnt++;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    chk("vec_latency", n, 5);
    chk("vec_data", bus.out_data, v.dout);
    chk("vec_nibble", bus.out_nibble, v.nib);
    chk("vec_syn", bus.out_syndrome, v.syn);
    chk("vec_err", bus.out_err, v.err);
    chk("vec_id", bus.out_id, v.id);
    chk("vec_cnt", err_cnt, exp_cnt);
    @(posedge clk);
  endtask

  task automatic send2(input logic [6:0] d,
                       input bit clr_fix,
                       input int expc);
    int n;
    @(negedge clk);
    bus2.req0_valid = 1'b1;
    bus2.req0_data  = d;
    bus2.mode       = 1'b1;
    @(posedge clk);
    #1;
    bus2.req0_valid = 1'b0;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (clr_fix && n == 4) clr2 = 1'b1;
      if (n == 5) clr2 = 1'b0;
      if (bus2.out_valid) break;
    end
    chk("sat_latency", n, 5);
    chk("sat_cnt", cnt2, expc);
    @(posedge clk);
  endtask

  initial begin
    int ng;
    int nv;
    int gcyc[4];
    logic gid[4];
    logic vid[4];
    int k;

    vt[0] = '{1'b0, 1'b1, 7'h66, 7'h66, 4'hD, 3'd0, 1'b0};
    vt[1] = '{1'b1, 1'b1, 7'h76, 7'h66, 4'hD, 3'd5, 1'b1};
    vt[2] = '{1'b0, 1'b0, 7'h6D, 7'h6D, 4'hD, 3'd0, 1'b0};
    vt[3] = '{1'b1, 1'b0, 7'h6C, 7'h6D, 4'hD, 3'd1, 1'b1};
    vt[4] = '{1'b0, 1'b1, 7'h00, 7'h00, 4'h0, 3'd0, 1'b0};
    vt[5] = '{1'b1, 1'b1, 7'h01, 7'h00, 4'h0, 3'd1, 1'b1};
    vt[6] = '{1'b0, 1'b1, 7'h40, 7'h00, 4'h0, 3'd7, 1'b1};
    vt[7] = '{1'b1, 1'b1, 7'h7F, 7'h7F, 4'hF, 3'd0, 1'b0};
    vt[8] = '{1'b0, 1'b0, 7'h00, 7'h40, 4'h8, 3'd7, 1'b1};
    vt[9] = '{1'b0, 1'b1, 7'h08, 7'h00, 4'h0, 3'd4, 1'b1};

    bus.req0_valid  = 1'b1;
    bus.req1_valid  = 1'b1;
    bus.req0_data   = 7'h55;
    bus.req1_data   = 7'h2A;
    bus.mode        = 1'b1;
    bus.out_ready   = 1'b1;
    bus2.req0_valid = 1'b0;
    bus2.req1_valid = 1'b0;
    bus2.req0_data  = '0;
    bus2.req1_data  = '0;
    bus2.mode       = 1'b1;
    bus2.out_ready  = 1'b1;

    // Reset state, with both valids asserted
    #13;
    chk("rst_ready0", bus.req0_ready, 0);
    chk("rst_ready1", bus.req1_ready, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_nib", bus.out_nibble, 0);
    chk("rst_syn", bus.out_syndrome, 0);
    chk("rst_err", bus.out_err, 0);
    chk("rst_id", bus.out_id, 0);
    chk("rst_cnt", err_cnt, 0);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vt[i]);

    // Backpressure: result held, waiting req1 not granted
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(1'b0, 1'b1, 7'h76, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 7'h00, 1'b0);
    exp_cnt++;
    k = 0;
    while (!bus.out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("bp_reach_out", bus.out_valid, 1);
    drive(1'b1, 1'b1, 7'h66, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", bus.out_valid, 1);
      chk("bp_hold_data", bus.out_data, 7'h66);
      chk("bp_hold_syn", bus.out_syndrome, 5);
      chk("bp_no_ready",
          bus.req0_ready | bus.req1_ready, 0);
    end
    chk("bp_cnt", err_cnt, exp_cnt);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_grant1", bus.req1_ready, 1);
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 7'h00, 1'b0);
    @(posedge clk);
    // Now in CHK2: reset mid-operation
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cnt", err_cnt, 0);
    chk("mid_rst_data", bus.out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_quiet",
          bus.out_valid | busy, 0);
    end

    // Both requesters valid straight out of reset
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 7'h66, 1'b1);
    drive(1'b1, 1'b1, 7'h66, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    ng = 0;
    nv = 0;
    for (int c = 0; c < 80 && (ng < 4 || nv < 4); c++) begin
      #1;
      chk("rr_no_double",
          bus.req0_ready & bus.req1_ready, 0);
      if ((bus.req0_ready | bus.req1_ready) && ng < 4) begin
        gid[ng]  = bus.req1_ready;
        gcyc[ng] = c;
        ng++;
      end
      if (bus.out_valid && nv < 4) begin
        vid[nv] = bus.out_id;
        nv++;
      end
      @(negedge clk);
    end
    chk("rr_grants", ng, 4);
    chk("rr_outs", nv, 4);
    chk("rr_first_cycle", gcyc[0], 0);
    for (int i = 0; i < 4; i++) begin
      chk("rr_grant_order", gid[i], i % 2);
      chk("rr_out_id", vid[i], i % 2);
    end
    for (int i = 1; i < 4; i++)
      chk("rr_spacing", gcyc[i] - gcyc[i-1], 6);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    k = 0;
    while (busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rr_drain", busy, 0);

    // Saturation with a 2-bit counter
    send2(7'h76, 1'b0, 1);
    send2(7'h76, 1'b0, 2);
    send2(7'h76, 1'b0, 3);
    send2(7'h76, 1'b0, 3);
    send2(7'h76, 1'b0, 3);
    send2(7'h76, 1'b1, 0);
    send2(7'h66, 1'b0, 0);
    send2(7'h76, 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
